// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selects and payload width.
package uart_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LAUNCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_END   = 3'd3;
    localparam logic [2:0] ST_COMPLETE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        LAUNCH     = ST_LAUNCH,
        WAIT_START = ST_WAIT_START,
        WAIT_END   = ST_WAIT_END,
        COMPLETE   = ST_COMPLETE
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bundle around the shared UART transmitter.
interface uart_tx_arbiter_if import uart_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_parity_type;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            done;
    logic                          done_err;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_parity_type;
    logic                          tx_done;
    logic [IW-1:0]                 grant_id;
    logic                          busy;

    modport slave (
        input  req, req_data, req_parity_type, tx_done,
        output ack, done, done_err, tx_start, tx_data, tx_parity_type, grant_id, busy
    );

    modport master (
        output req, req_data, req_parity_type, tx_done,
        input  ack, done, done_err, tx_start, tx_data, tx_parity_type, grant_id, busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating first-one finder: first set req bit after ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    int pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        // k = N wraps back to ptr itself, so a lone requester can still win
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; tracks each frame via tx_done and reports done/timeout.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int START_TIMEOUT = 64
) (
    input  logic              clk2,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT);

    tx_state_t       state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   tmo_cnt;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            ptr                <= IW'(NUM_REQ - 1);
            tmo_cnt            <= '0;
            bus.ack            <= '0;
            bus.done           <= '0;
            bus.done_err       <= 1'b0;
            bus.tx_start       <= 1'b0;
            bus.tx_data        <= '0;
            bus.tx_parity_type <= PARITY_EVEN;
            bus.grant_id       <= '0;
            bus.busy           <= 1'b0;
        end else begin
            bus.ack      <= '0;
            bus.done     <= '0;
            bus.done_err <= 1'b0;
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        ptr                <= pick_idx;
                        bus.grant_id       <= pick_idx;
                        bus.tx_data        <= bus.req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        bus.tx_parity_type <= bus.req_parity_type[pick_idx];
                        bus.ack[pick_idx]  <= 1'b1;
                        bus.tx_start       <= 1'b1;
                        bus.busy           <= 1'b1;
                        state              <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    // A transmitter that is already busy on the first cycle counts as started
                    if (!bus.tx_done) begin
                        state <= WAIT_END;
                    end else if (tmo_cnt == CW'(START_TIMEOUT - 1)) begin
                        bus.done[bus.grant_id] <= 1'b1;
                        bus.done_err           <= 1'b1;
                        bus.busy               <= 1'b0;
                        state                  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_END: begin
                    if (bus.tx_done) begin
                        bus.done[bus.grant_id] <= 1'b1;
                        state                  <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
